// File: rtl/quadrilatero_pkg.sv
// Shared types and constants for the quadrilatero matrix load/store path.
package quadrilatero_pkg;

  localparam int unsigned N_REGS = 8;
  localparam int unsigned N_ROWS = 4;
  localparam int unsigned RLEN   = 128;
  localparam int unsigned WPR    = RLEN / 32;
  localparam int unsigned REG_W  = $clog2(N_REGS);

  // Issued instruction, shared with the issue controller
  typedef struct packed {
    logic [REG_W-1:0] operand_reg;
    logic [31:0]      addr;
    logic [31:0]      stride;
    logic             is_store;
  } lsu_instr_t;

  // CSR configuration captured together with the instruction
  typedef struct packed {
    logic [7:0] n_row;
    logic [7:0] n_col_bytes;
  } lsu_conf_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/quadrilatero_lsu_addr_gen.sv
// Request-side walker: row/word counters, running byte address and last-request flag.
module quadrilatero_lsu_addr_gen #(
  parameter int unsigned ROW_W  = 2,
  parameter int unsigned WORD_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_i,
  input  logic [31:0]       base_i,
  input  logic [31:0]       stride_i,
  input  logic [ROW_W:0]    rows_i,
  input  logic [WORD_W:0]   words_i,
  input  logic              adv_i,
  output logic [31:0]       addr_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [WORD_W-1:0] word_o,
  output logic              last_o
);

  logic [31:0]       row_base_q, row_base_d;
  logic [31:0]       addr_q, addr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_last, row_last;

  assign word_last = ({1'b0, word_q} == (words_i - (WORD_W+1)'(1)));
  assign row_last  = ({1'b0, row_q} == (rows_i - (ROW_W+1)'(1)));

  // Next position: restart at base, or step one word; a row change adds the stride
  // to the row base so the word offset never has to be multiplied out.
  always_comb begin
    row_base_d = row_base_q;
    addr_d     = addr_q;
    row_d      = row_q;
    word_d     = word_q;
    if (init_i) begin
      row_base_d = base_i;
      addr_d     = base_i;
      row_d      = '0;
      word_d     = '0;
    end else if (adv_i) begin
      if (word_last) begin
        word_d     = '0;
        row_d      = row_q + ROW_W'(1);
        row_base_d = row_base_q + stride_i;
        addr_d     = row_base_q + stride_i;
      end else begin
        word_d = word_q + WORD_W'(1);
        addr_d = addr_q + 32'd4;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_base_q <= '0;
      addr_q     <= '0;
      row_q      <= '0;
      word_q     <= '0;
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      word_q     <= word_d;
    end
  end

  assign addr_o = addr_q;
  assign row_o  = row_q;
  assign word_o = word_q;
  assign last_o = word_last & row_last;

endmodule

// File: rtl/quadrilatero_register_lsu.sv
// Matrix load/store execution stage: walks rows x words between OBI memory and the RF.
module quadrilatero_register_lsu
  import quadrilatero_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     start_i,
  input  lsu_instr_t                               instr_i,
  input  lsu_conf_t                                conf_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     mem_req_o,
  input  logic                                     mem_gnt_i,
  output logic [31:0]                              mem_addr_o,
  output logic                                     mem_we_o,
  output logic [3:0]                               mem_be_o,
  output logic [31:0]                              mem_wdata_o,
  input  logic                                     mem_rvalid_i,
  input  logic [31:0]                              mem_rdata_i,
  output logic                                     rf_we_o,
  output logic [REG_W-1:0]                         rf_reg_o,
  output logic [$clog2(N_ROWS)+$clog2(WPR)-1:0]    rf_waddr_o,
  output logic [31:0]                              rf_wdata_o,
  output logic [$clog2(N_ROWS)+$clog2(WPR)-1:0]    rf_raddr_o,
  input  logic [31:0]                              rf_rdata_i
);

  localparam int unsigned ROW_W  = $clog2(N_ROWS);
  localparam int unsigned WORD_W = $clog2(WPR);
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  lsu_state_e        state_q, state_d;
  logic [REG_W-1:0]  reg_q;
  logic [31:0]       stride_q;
  logic              store_q;
  logic [ROW_W:0]    rows_q;
  logic [WORD_W:0]   words_q;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [ROW_W-1:0]  pr_q;
  logic [WORD_W-1:0] pw_q;

  logic [ROW_W:0]    rows_eff;
  logic [WORD_W:0]   words_eff;
  logic [7:0]        n_words;
  logic              accept, in_req, active, gnt_hs, rsp_hs, last_req;
  logic [31:0]       req_addr;
  logic [ROW_W-1:0]  rr;
  logic [WORD_W-1:0] rw;

  // Clamp the requested shape to the register geometry; partial words are dropped
  assign n_words   = conf_i.n_col_bytes >> 2;
  assign rows_eff  = (conf_i.n_row > 8'(N_ROWS)) ? (ROW_W+1)'(N_ROWS) : (ROW_W+1)'(conf_i.n_row);
  assign words_eff = (n_words > 8'(WPR)) ? (WORD_W+1)'(WPR) : (WORD_W+1)'(n_words);

  assign accept   = (state_q == IDLE) && start_i;
  assign in_req   = (state_q == REQ);
  assign active   = (state_q == REQ) || (state_q == DRAIN);
  assign gnt_hs   = mem_req_o && mem_gnt_i;
  // Responses only count while an instruction owns the port and one is actually owed
  assign rsp_hs   = mem_rvalid_i && active && (outst_q != '0);

  quadrilatero_lsu_addr_gen #(
    .ROW_W  (ROW_W),
    .WORD_W (WORD_W)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .init_i   (accept),
    .base_i   (instr_i.addr),
    .stride_i (stride_q),
    .rows_i   (rows_q),
    .words_i  (words_q),
    .adv_i    (gnt_hs),
    .addr_o   (req_addr),
    .row_o    (rr),
    .word_o   (rw),
    .last_o   (last_req)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = ((rows_eff == '0) || (words_eff == '0)) ? DONE : REQ;
      REQ:     if (gnt_hs && last_req) state_d = DRAIN;
      DRAIN:   if (outst_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outstanding count: grant adds one, response retires one, both together cancel
  always_comb begin
    outst_d = outst_q;
    if (gnt_hs && !rsp_hs)      outst_d = outst_q + OUT_W'(1);
    else if (!gnt_hs && rsp_hs) outst_d = outst_q - OUT_W'(1);
  end

  // State, latched instruction and response position
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      reg_q    <= '0;
      stride_q <= '0;
      store_q  <= 1'b0;
      rows_q   <= '0;
      words_q  <= '0;
      outst_q  <= '0;
      pr_q     <= '0;
      pw_q     <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (accept) begin
        reg_q    <= instr_i.operand_reg;
        stride_q <= instr_i.stride;
        store_q  <= instr_i.is_store;
        rows_q   <= rows_eff;
        words_q  <= words_eff;
        pr_q     <= '0;
        pw_q     <= '0;
      end else if (rsp_hs) begin
        if ({1'b0, pw_q} == (words_q - (WORD_W+1)'(1))) begin
          pw_q <= '0;
          pr_q <= pr_q + ROW_W'(1);
        end else begin
          pw_q <= pw_q + WORD_W'(1);
        end
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign mem_req_o   = in_req && (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign mem_addr_o  = in_req ? req_addr : '0;
  assign mem_we_o    = in_req && store_q;
  assign mem_be_o    = 4'hF;
  assign mem_wdata_o = (in_req && store_q) ? rf_rdata_i : '0;
  assign rf_raddr_o  = (in_req && store_q) ? {rr, rw} : '0;
  assign rf_reg_o    = reg_q;
  assign rf_we_o     = rsp_hs && !store_q;
  assign rf_waddr_o  = rf_we_o ? {pr_q, pw_q} : '0;
  assign rf_wdata_o  = rf_we_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_quadrilatero_register_lsu.sv
// Randomized bench: a memory model with in-order delayed responses and an RF array,
// checked against the expected row-major transfer list derived from the instruction.
module tb_quadrilatero_register_lsu;
  import quadrilatero_pkg::*;

  localparam int MAXO = 2;
  localparam int RPW  = N_ROWS * WPR;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  lsu_instr_t  instr_i;
  lsu_conf_t   conf_i;
  logic        busy_o, done_o, mem_req_o, mem_we_o, rf_we_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, rf_wdata_o, rf_rdata_i;
  logic [3:0]  mem_be_o;
  logic [REG_W-1:0] rf_reg_o;
  logic [3:0]  rf_waddr_o, rf_raddr_o;

  logic [31:0] rf_mem [N_REGS*RPW];
  int          rsp_q [$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  assign rf_rdata_i = rf_mem[{rf_reg_o, rf_raddr_o}];

  quadrilatero_register_lsu #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .instr_i(instr_i), .conf_i(conf_i),
    .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rf_we_o(rf_we_o), .rf_reg_o(rf_reg_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
    check_eq({tag, "_req"}, mem_req_o, 0);
    check_eq({tag, "_addr"}, mem_addr_o, 0);
    check_eq({tag, "_we"}, mem_we_o, 0);
    check_eq({tag, "_be"}, mem_be_o, 4'hF);
    check_eq({tag, "_rfwe"}, rf_we_o, 0);
  endtask

  // One instruction: drive start, serve the memory side, compare every cycle.
  task automatic run_instr(input logic [31:0] base, input logic [31:0] stride,
                           input int n_row, input int ncb, input int reg_idx, input bit st,
                           input int gnt_pct, input int stall_n, input int dly_min,
                           input int dly_max, input bit abort);
    int rows, words, total, req_idx, rsp_idx, outst, done_cnt, done_cyc, stalls, idx, d;
    bit gnt, rv, finished, aborted, exp_req;
    logic [31:0] exp_addr, rdata, r32;
    rows     = (n_row > N_ROWS) ? N_ROWS : n_row;
    words    = ((ncb / 4) > WPR) ? WPR : (ncb / 4);
    total    = rows * words;
    req_idx  = 0; rsp_idx = 0; outst = 0; done_cnt = 0; done_cyc = -1; stalls = 0;
    finished = 0; aborted = 0;

    @(negedge clk_i);
    instr_i.operand_reg = REG_W'(reg_idx);
    instr_i.addr        = base;
    instr_i.stride      = stride;
    instr_i.is_store    = st;
    conf_i.n_row        = 8'(n_row);
    conf_i.n_col_bytes  = 8'(ncb);
    start_i             = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;

    for (int c = 0; c < 600 && !finished && !aborted; c++) begin
      if (c > 0) @(negedge clk_i);
      cyc++;
      gnt = (req_idx == 0 && stalls < stall_n) ? 1'b0 : ($urandom_range(99) < gnt_pct);
      rv  = (rsp_q.size() > 0) && (rsp_q[0] <= cyc);
      rdata = $urandom;
      if (rv) void'(rsp_q.pop_front());
      mem_gnt_i    = gnt;
      mem_rvalid_i = rv;
      mem_rdata_i  = rdata;
      #1;
      if (abort && total > 0 && req_idx == total && outst == 1 && !rv) begin
        aborted = 1;
      end else begin
        if (done_cnt == 0) check_eq("busy", busy_o, 1);
        exp_req = (total > 0) && (req_idx < total) && (outst < MAXO);
        check_eq("mem_req", mem_req_o, exp_req);
        if (mem_req_o && exp_req) begin
          r32 = req_idx / words;
          exp_addr = base + r32 * stride + 32'((req_idx % words) * 4);
          check_eq("mem_addr", mem_addr_o, exp_addr);
          check_eq("mem_we", mem_we_o, st);
          check_eq("mem_be", mem_be_o, 4'hF);
          if (st) begin
            idx = reg_idx * RPW + (req_idx / words) * WPR + (req_idx % words);
            check_eq("mem_wdata", mem_wdata_o, rf_mem[idx]);
          end
          if (!gnt && req_idx == 0) stalls++;
          if (gnt) begin
            d = cyc + $urandom_range(dly_max, dly_min);
            if (rsp_q.size() > 0 && d < rsp_q[$]) d = rsp_q[$];
            rsp_q.push_back(d);
            req_idx++;
            outst++;
          end
        end
        if (rv) begin
          if (!st) begin
            idx = (rsp_idx / words) * WPR + (rsp_idx % words);
            check_eq("rf_we", rf_we_o, 1);
            check_eq("rf_waddr", rf_waddr_o, idx);
            check_eq("rf_reg", rf_reg_o, reg_idx);
            check_eq("rf_wdata", rf_wdata_o, rdata);
            rf_mem[reg_idx * RPW + idx] = rdata;
          end else begin
            check_eq("rf_we_store", rf_we_o, 0);
          end
          rsp_idx++;
          outst--;
        end else begin
          check_eq("rf_we_quiet", rf_we_o, 0);
        end
        if (done_o) begin
          check_eq("done_early", (rsp_idx == total && req_idx == total), 1);
          done_cnt++;
          done_cyc = c;
          finished = 1;
        end
      end
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;

    if (aborted) begin
      rst_ni = 1'b0;
      #1;
      check_idle_outputs("abort");
      for (int k = 0; k < 8; k++) begin
        @(negedge clk_i);
        cyc++;
        rst_ni = 1'b1;
        rv = (rsp_q.size() > 0) && (rsp_q[0] <= cyc);
        if (rv) void'(rsp_q.pop_front());
        mem_rvalid_i = rv;
        mem_rdata_i  = $urandom;
        #1;
        check_eq("late_rf_we", rf_we_o, 0);
        check_eq("late_busy", busy_o, 0);
      end
      mem_rvalid_i = 1'b0;
      check_eq("late_rsp_seen", rsp_q.size(), 0);
      rsp_q.delete();
      $display("instr reg=%0d st=%0d base=%08h rows=%0d words=%0d: aborted by reset after %0d grants",
               reg_idx, st, base, rows, words, req_idx);
    end else begin
      @(negedge clk_i);
      cyc++;
      #1;
      check_eq("busy_after_done", busy_o, 0);
      check_eq("done_pulse", done_o, 0);
      check_eq("done_once", done_cnt, 1);
      check_eq("req_count", req_idx, total);
      check_eq("rsp_count", rsp_idx, total);
      if (total == 0) check_eq("zero_done_cycle", done_cyc, 0);
      $display("instr reg=%0d st=%0d base=%08h stride=%08h rows=%0d words=%0d: %0d req, %0d rsp, done at +%0d",
               reg_idx, st, base, stride, rows, words, req_idx, rsp_idx, done_cyc);
    end
  endtask

  initial begin
    instr_i = '0;
    conf_i  = '0;
    mem_rdata_i = '0;
    for (int i = 0; i < N_REGS * RPW; i++) rf_mem[i] = $urandom;

    repeat (3) @(negedge clk_i);
    #1;
    check_idle_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed cases
    run_instr(32'h0000_1000, 32'h40, 4, 16, 3, 0, 100, 0, 1, 1, 0);
    run_instr(32'h0000_2000, 32'h80, 2, 8, 5, 1, 100, 3, 1, 1, 0);
    run_instr(32'h0000_3000, 32'h100, 4, 16, 1, 0, 100, 0, 5, 5, 0);
    run_instr(32'h0000_3000, 32'h100, 4, 16, 2, 1, 100, 0, 5, 5, 0);
    run_instr(32'h0000_5000, 32'h10, 0, 16, 1, 0, 100, 0, 1, 1, 0);
    run_instr(32'h0000_5000, 32'h10, 4, 3, 1, 1, 100, 0, 1, 1, 0);
    run_instr(32'hFFFF_FFF8, 32'h10, 9, 40, 6, 0, 100, 0, 1, 2, 0);
    run_instr(32'h0000_4000, 32'h20, 1, 4, 2, 0, 100, 0, 5, 5, 1);
    run_instr(32'h0000_6000, 32'h30, 3, 12, 4, 0, 100, 0, 1, 3, 0);

    // Randomized cases
    for (int t = 0; t < 30; t++) begin
      run_instr($urandom & 32'hFFFF_FFFC, $urandom_range(255) * 4, $urandom_range(6),
                $urandom_range(20), $urandom_range(N_REGS - 1), $urandom_range(1),
                $urandom_range(100, 30), $urandom_range(3), 1, $urandom_range(6, 1), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
